// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous memory between fetch and load/store ports.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_ready,
    output logic                  dm_rvalid,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]           conflict_count,
    output logic [15:0]           forced_count
`endif
);

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    logic       r_rd_pending;
    owner_t     r_rd_owner;
    logic [3:0] r_starve_cnt;

    logic w_force;
    logic w_if_gnt;
    logic w_dm_gnt;

    always_comb begin
        w_force  = 1'b0;
        w_if_gnt = 1'b0;
        w_dm_gnt = 1'b0;
        if (!rst) begin
            w_force = if_req && (r_starve_cnt == 4'(MAX_WAIT));
            if (w_force)     w_if_gnt = 1'b1;
            else if (dm_req) w_dm_gnt = 1'b1;
            else if (if_req) w_if_gnt = 1'b1;
        end
    end

    always_comb begin
        if_ready  = w_if_gnt;
        dm_ready  = w_dm_gnt;
        mem_en    = w_if_gnt | w_dm_gnt;
        mem_we    = w_dm_gnt & dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_dm_gnt)      mem_addr = dm_addr;
        else if (w_if_gnt) mem_addr = if_addr;
        if (mem_en)        mem_wdata = dm_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pending <= 1'b0;
            r_rd_owner   <= OWN_IF;
            r_starve_cnt <= '0;
        end else begin
            r_rd_pending <= w_if_gnt | (w_dm_gnt & ~dm_we);
            r_rd_owner   <= w_dm_gnt ? OWN_DM : OWN_IF;
            // Counts only cycles where fetch is asking and losing; saturates at the forcing threshold.
            if (if_req && !w_if_gnt)
                r_starve_cnt <= (r_starve_cnt == 4'(MAX_WAIT)) ? r_starve_cnt : r_starve_cnt + 4'd1;
            else
                r_starve_cnt <= '0;
        end
    end

    always_comb begin
        if_rvalid = r_rd_pending && (r_rd_owner == OWN_IF);
        dm_rvalid = r_rd_pending && (r_rd_owner == OWN_DM);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_count <= '0;
            forced_count   <= '0;
        end else begin
            if (if_req && dm_req) conflict_count <= conflict_count + 32'd1;
            if (w_force)          forced_count   <= forced_count + 16'd1;
        end
    end
`endif

endmodule
